cfg_frame_loader: RTL



---
 rtl/cfg_frame_loader_pkg.sv | 18 +
 rtl/cfg_frame_loader_if.sv | 23 ++
 rtl/cfg_frame_loader_crc8.sv | 20 ++
 rtl/cfg_frame_loader.sv | 137 +++++++++++++
 4 files changed

// File: rtl/cfg_frame_loader_pkg.sv
// Shared types and constants for the configuration frame loader (package cfg_pkg).
package cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/cfg_frame_loader_if.sv
// Word-serial config stream in, wide active config bus out.
interface cfg_frame_loader_if #(
  parameter int CFG_W  = 248,
  parameter int WORD_W = 8
);
  logic              cfg_start;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [WORD_W-1:0] cfg_data;
  logic [CFG_W-1:0]  c_out;
  logic              cfg_done;
  logic              cfg_err;

  modport master (
    output cfg_start, cfg_valid, cfg_data,
    input  cfg_ready, c_out, cfg_done, cfg_err
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data,
    output cfg_ready, c_out, cfg_done, cfg_err
  );
endinterface

// File: rtl/cfg_frame_loader_crc8.sv
// Combinational CRC-8 update over one WORD_W word, MSB first (module cfg_crc8_step).
module cfg_crc8_step
  import cfg_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic [7:0]        crc_in,
  input  logic [WORD_W-1:0] data,
  output logic [7:0]        crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (crc_out[7] ^ data[i]) crc_out = {crc_out[6:0], 1'b0} ^ CRC8_POLY;
      else                      crc_out = {crc_out[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/cfg_frame_loader.sv
// Shadow-loads a config frame word by word and commits it atomically to c_out.
// Optional trailer CRC-8 check is enabled by defining CFG_FRAME_CRC_EN.
module cfg_frame_loader
  import cfg_pkg::*;
#(
  parameter int CFG_W  = 248,
  parameter int WORD_W = 8
) (
  input logic               clk,
  input logic               rst,
  cfg_frame_loader_if.slave bus
);

  localparam int NWORDS = ceil_div(CFG_W, WORD_W);
  localparam int SH_W   = NWORDS * WORD_W;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SH_W-1:0]          shadow_q, shadow_d;
  logic [CFG_W-1:0]         c_out_q, c_out_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     ready;
  logic [SH_W+WORD_W-1:0]   shift_cat;

`ifdef CFG_FRAME_CRC_EN
  logic [7:0] crc_q, crc_d, crc_next;

  cfg_crc8_step #(.WORD_W(WORD_W)) u_crc (
    .crc_in  (crc_q),
    .data    (bus.cfg_data),
    .crc_out (crc_next)
  );
`endif

  // Incoming word enters at the top so the first word ends up at the LSB end.
  assign shift_cat = {bus.cfg_data, shadow_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    c_out_d  = c_out_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    ready    = 1'b0;
`ifdef CFG_FRAME_CRC_EN
    crc_d    = crc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.cfg_start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
`ifdef CFG_FRAME_CRC_EN
          crc_d   = CRC8_INIT;
`endif
        end
      end
      ST_LOAD: begin
        ready = ~bus.cfg_start;
        if (bus.cfg_start) begin
          err_d = 1'b1;
          cnt_d = '0;
`ifdef CFG_FRAME_CRC_EN
          crc_d = CRC8_INIT;
`endif
        end else if (bus.cfg_valid) begin
          shadow_d = shift_cat[SH_W+WORD_W-1:WORD_W];
          cnt_d    = cnt_q + 1'b1;
`ifdef CFG_FRAME_CRC_EN
          crc_d    = crc_next;
          if (cnt_q == LAST_CNT) state_d = ST_CHECK;
`else
          if (cnt_q == LAST_CNT) state_d = ST_COMMIT;
`endif
        end
      end
`ifdef CFG_FRAME_CRC_EN
      ST_CHECK: begin
        ready = ~bus.cfg_start;
        if (bus.cfg_start) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          crc_d   = CRC8_INIT;
          state_d = ST_LOAD;
        end else if (bus.cfg_valid) begin
          if (bus.cfg_data[7:0] == crc_q) begin
            state_d = ST_COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
`endif
      ST_COMMIT: begin
        c_out_d = shadow_q[CFG_W-1:0];
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      c_out_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef CFG_FRAME_CRC_EN
      crc_q    <= CRC8_INIT;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      c_out_q  <= c_out_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef CFG_FRAME_CRC_EN
      crc_q    <= crc_d;
`endif
    end
  end

  assign bus.cfg_ready = ready;
  assign bus.c_out     = c_out_q;
  assign bus.cfg_done  = done_q;
  assign bus.cfg_err   = err_q;

endmodule
